// File: rtl/button_event_gen.sv
// Turns the debounced push-button level into one-clock press/release/long/repeat events and a hold timer.
// Define BUTTON_AUTOREPEAT_EN to build the repeat counter; otherwise repeat_pulse is tied low.
module button_event_gen #(
    parameter int CLK       = 50000000,
    parameter int TICK_HZ   = 1000,
    parameter int LONG_MS   = 500,
    parameter int REPEAT_MS = 100,
    parameter int HOLD_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PB_state,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              long_pulse,
    output logic              repeat_pulse,
    output logic              held,
    output logic [HOLD_W-1:0] hold_ms
);

    localparam int DIV = CLK / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]     DIV_LAST = PW'(DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
    localparam logic [HOLD_W-1:0] LONG_VAL = HOLD_W'(LONG_MS);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

    state_t            state, state_n;
    logic              pb_q;
    logic [PW-1:0]     presc;
    logic              tick, rise, fall;
    logic [HOLD_W-1:0] hold_inc, hold_n;
    logic              held_n, press_n, release_n, long_n;

    assign rise     = PB_state & ~pb_q;
    assign fall     = ~PB_state & pb_q;
    assign tick     = (presc == DIV_LAST);
    assign hold_inc = (hold_ms == HOLD_MAX) ? hold_ms : hold_ms + 1'b1;

    // pb_q resets high so a button already held at reset needs a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            pb_q  <= 1'b1;
            presc <= '0;
        end else begin
            pb_q <= PB_state;
            if (rise || tick)
                presc <= '0;
            else
                presc <= presc + 1'b1;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_MS + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_MS - 1);
    logic [RW-1:0] rcnt, rcnt_n;
    logic          repeat_n;
`endif

    always_comb begin
        state_n   = state;
        hold_n    = hold_ms;
        held_n    = held;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
        repeat_n  = 1'b0;
        rcnt_n    = rcnt;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    press_n = 1'b1;
                    hold_n  = '0;
                    held_n  = 1'b1;
                    state_n = PRESSED;
                end
            end
            PRESSED: begin
                // A release on a tick edge wins: no increment, no long event.
                if (fall) begin
                    release_n = 1'b1;
                    held_n    = 1'b0;
                    state_n   = IDLE;
                end else if (tick) begin
                    hold_n = hold_inc;
                    if (hold_inc == LONG_VAL) begin
                        long_n  = 1'b1;
                        state_n = LONG;
`ifdef BUTTON_AUTOREPEAT_EN
                        rcnt_n  = '0;
`endif
                    end
                end
            end
            LONG: begin
                if (fall) begin
                    release_n = 1'b1;
                    held_n    = 1'b0;
                    state_n   = IDLE;
                end else if (tick) begin
                    hold_n = hold_inc;
`ifdef BUTTON_AUTOREPEAT_EN
                    if (rcnt == REP_LAST) begin
                        repeat_n = 1'b1;
                        rcnt_n   = '0;
                    end else begin
                        rcnt_n = rcnt + 1'b1;
                    end
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hold_ms       <= '0;
            held          <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_n;
            hold_ms       <= hold_n;
            held          <= held_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt         <= '0;
            repeat_pulse <= 1'b0;
        end else begin
            rcnt         <= rcnt_n;
            repeat_pulse <= repeat_n;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen: expected pulse events are queued as stimulus is driven
// and matched (edge number, kind, hold_ms) whenever the DUT pulses.
module tb_button_event_gen;

    localparam int HW = 8;
    localparam logic [3:0] K_PRESS = 4'b0001, K_REL = 4'b0010, K_LONG = 4'b0100, K_REP = 4'b1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          PB_state = 1'b0;
    logic          press_pulse, release_pulse, long_pulse, repeat_pulse, held;
    logic [HW-1:0] hold_ms;

    typedef struct {
        int         cyc;
        logic [3:0] kind;
        int         hold;
    } ev_t;

    ev_t exp_q[$];
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    button_event_gen #(
        .CLK(1000), .TICK_HZ(100), .LONG_MS(5), .REPEAT_MS(2), .HOLD_W(HW)
    ) dut (
        .clk(clk), .rst(rst), .PB_state(PB_state),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
        .held(held), .hold_ms(hold_ms)
    );

    always #5 clk = ~clk;

    // cyc holds the number of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic push(input int c, input logic [3:0] k, input int h);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.hold = h;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic pb, input logic r);
        @(negedge clk);
        PB_state = pb;
        rst      = r;
    endtask

    task automatic waitUntil(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Raise the button; e is the edge that samples the rise.
    task automatic riseButton(output int e);
        applyStimulus(1'b1, 1'b0);
        e = cyc + 1;
    endtask

    // Drop the button so that the fall is sampled on edge e+h.
    task automatic fallAfter(input int e, input int h);
        waitUntil(e + h - 1);
        PB_state = 1'b0;
    endtask

    // Scoreboard: every pulse, and every expected event whose edge has passed, pops one entry.
    always @(negedge clk) begin
        logic [3:0] obs;
        ev_t        e;
        obs = {repeat_pulse, long_pulse, release_pulse, press_pulse};
        if (obs != 4'b0 || (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", 32'(obs), 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("event_kind", 32'(obs), 32'(e.kind));
                checkOutput("event_edge", 32'(cyc), 32'(e.cyc));
                checkOutput("event_hold_ms", 32'(hold_ms), 32'(e.hold));
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e;

        // Reset with button released.
        applyStimulus(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("reset_held", 32'(held), 32'd0);
        checkOutput("reset_hold_ms", 32'(hold_ms), 32'd0);
        checkOutput("reset_pulses", 32'({repeat_pulse, long_pulse, release_pulse, press_pulse}), 32'd0);
        applyStimulus(1'b0, 1'b0);
        repeat (7) @(negedge clk);

        // Short press: ticks at e+10, e+20, e+30, fall at e+35.
        riseButton(e);
        push(e, K_PRESS, 0);
        push(e + 35, K_REL, 3);
        waitUntil(e + 5);
        checkOutput("short_held", 32'(held), 32'd1);
        fallAfter(e, 35);
        waitUntil(e + 60);
        checkOutput("short_released", 32'(held), 32'd0);
        checkOutput("short_hold_frozen", 32'(hold_ms), 32'd3);

        // Long press of 75 cycles: long at 5th tick, repeat two ticks later.
        riseButton(e);
        push(e, K_PRESS, 0);
        push(e + 50, K_LONG, 5);
`ifdef BUTTON_AUTOREPEAT_EN
        push(e + 70, K_REP, 7);
`endif
        push(e + 75, K_REL, 7);
        fallAfter(e, 75);
        waitUntil(e + 85);
        checkOutput("long_hold_ms", 32'(hold_ms), 32'd7);
        checkOutput("long_held", 32'(held), 32'd0);

        // Fall sampled on the 5th tick: release wins, no long, no increment.
        riseButton(e);
        push(e, K_PRESS, 0);
        push(e + 50, K_REL, 4);
        fallAfter(e, 50);
        waitUntil(e + 60);
        checkOutput("coincide_hold_ms", 32'(hold_ms), 32'd4);

        // Button held through reset is ignored until re-pressed.
        applyStimulus(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("held_thru_reset", 32'(held), 32'd0);
        applyStimulus(1'b0, 1'b0);
        repeat (8) @(negedge clk);
        checkOutput("ignored_release_held", 32'(held), 32'd0);
        riseButton(e);
        push(e, K_PRESS, 0);
        push(e + 12, K_REL, 1);
        fallAfter(e, 12);
        waitUntil(e + 20);
        checkOutput("repress_hold_ms", 32'(hold_ms), 32'd1);

        // Very long hold: saturation at 255, repeats every 20 cycles, then reset mid-hold.
        riseButton(e);
        push(e, K_PRESS, 0);
        push(e + 50, K_LONG, 5);
`ifdef BUTTON_AUTOREPEAT_EN
        for (int k = 1; k <= 137; k++)
            push(e + 50 + 20 * k, K_REP, (5 + 2 * k > 255) ? 255 : 5 + 2 * k);
`endif
        waitUntil(e + 2600);
        checkOutput("sat_hold_ms", 32'(hold_ms), 32'd255);
        checkOutput("sat_held", 32'(held), 32'd1);
        waitUntil(e + 2799);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_held", 32'(held), 32'd0);
        checkOutput("midreset_hold_ms", 32'(hold_ms), 32'd0);
        checkOutput("midreset_pulses", 32'({repeat_pulse, long_pulse, release_pulse, press_pulse}), 32'd0);
        applyStimulus(1'b1, 1'b0);
        repeat (30) @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("final_held", 32'(held), 32'd0);
        checkOutput("pending_events", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
